// File: rtl/mem_port_master_pkg.sv
// Shared constants for the single-port synchronous memory and its initiators.
// Both sides import these so data/address widths stay in lockstep.
package mem_port_master_pkg;

    localparam int MEM_DW = 16;
    localparam int MEM_AW = 25;
    localparam int RSP_DEPTH_DEF = 4;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous response FIFO for mem_port_master.
// Head entry is presented combinationally from storage at the read pointer.
module mem_rsp_fifo
    import mem_port_master_pkg::*;
#(
    parameter  int DW    = MEM_DW,
    parameter  int DEPTH = RSP_DEPTH_DEF,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count
);

    logic [DW-1:0] store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    // A pop against an empty FIFO is ignored rather than corrupting pointers.
    assign do_pop = pop & (count != '0);
    assign head   = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (push) begin
                store[wr_ptr] <= wdata;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_master.sv
// Initiator that turns a valid/ready request channel into memory port cycles
// and returns registered read data through a valid/ready response FIFO.
module mem_port_master
    import mem_port_master_pkg::*;
#(
    parameter  int DW        = MEM_DW,
    parameter  int AW        = MEM_AW,
    parameter  int RSP_DEPTH = RSP_DEPTH_DEF,
    localparam int LW        = level_width(RSP_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wen,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [LW-1:0] rsp_level,
    output logic          mem_cs,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic          rd_pend;
    logic          acc;
    logic          pop;
    logic [LW-1:0] count;
    logic [LW-1:0] level;
    logic [DW-1:0] head;

    // Reserve a FIFO slot for the read in flight so a push never overflows.
    assign level     = count + LW'(rd_pend);
    assign req_ready = rst_n & (level < LW'(RSP_DEPTH));
    assign acc       = req_valid & req_ready;

    assign mem_cs    = acc;
    assign mem_wen   = req_wen;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;

    assign rsp_valid = rst_n & (count != '0);
    assign rsp_rdata = rsp_valid ? head : '0;
    assign rsp_level = rst_n ? level : '0;
    assign pop       = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= acc & ~req_wen;
        end
    end

    mem_rsp_fifo #(
        .DW    (DW),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_pend),
        .wdata (mem_rdata),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: behavioural memory, array/queue reference model,
// directed scenarios plus a randomized traffic run.
module tb_mem_port_master;
    import mem_port_master_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 25;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wen = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [LW-1:0] rsp_level;
    logic          mem_cs;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;
    int cs_cnt = 0;

    logic [DW-1:0] tmem [1024];
    logic [DW-1:0] rmem [1024];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];

    always #5 clk = ~clk;

    mem_port_master #(
        .DW        (DW),
        .AW        (AW),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_level (rsp_level),
        .mem_cs    (mem_cs),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-port memory with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wen) tmem[mem_addr[9:0]] <= mem_wdata;
            else         mem_rdata <= tmem[mem_addr[9:0]];
        end
    end

    // Reference: reads see memory as of their accept order; responses in order.
    always @(negedge clk) begin
        if (mem_cs) cs_cnt++;
        if (req_valid && req_ready) begin
            if (req_wen) rmem[req_addr[9:0]] = req_wdata;
            else         exp_q.push_back(rmem[req_addr[9:0]]);
        end
        if (rsp_valid && rsp_ready) got_q.push_back(rsp_rdata);
        total++;
        if (rsp_level > LW'(DEPTH)) begin
            bad++;
            $display("FAIL level_bound: got %0d, max %0d", rsp_level, DEPTH);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic issue(input logic w, input int a, input logic [DW-1:0] d);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_wen   = w;
        req_addr  = AW'(a);
        req_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = req_ready;
            tick();
        end
        req_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: addr %0h never accepted", a);
        end
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        logic [DW+LW+2:0] obs;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = AW'(5);
        req_wdata = 16'hDEAD;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {req_ready, mem_cs, rsp_valid, rsp_level, rsp_rdata};
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_outputs cyc %0d: got %0h, want 0", c, obs);
            end
            tick();
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_level !== '0) begin
            bad++;
            $display("FAIL reset_release: ready %b level %0d, want 1/0",
                     req_ready, rsp_level);
        end
        tick();
    endtask

    task automatic test_write_read();
        clear_q();
        rsp_ready = 1'b1;
        cs_cnt    = 0;
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = AW'(16'h10);
        req_wdata = 16'hBEEF;
        tick();
        req_wen = 1'b0;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL wr_rd_early: rsp_valid %b, want 0", rsp_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL wr_rd_data: valid %b data %h, want 1/beef",
                     rsp_valid, rsp_rdata);
        end
        repeat (3) tick();
        total++;
        if (cs_cnt !== 2 || got_q.size() !== 1) begin
            bad++;
            $display("FAIL wr_rd_cs: cs %0d rsps %0d, want 2/1",
                     cs_cnt, got_q.size());
        end
    endtask

    task automatic test_streaming();
        logic [11:0] vmask;
        bit          rdy_all;
        for (int i = 0; i < 8; i++) issue(1'b1, i, DW'(16'h1000 + i));
        clear_q();
        rsp_ready = 1'b1;
        rdy_all   = 1'b1;
        vmask     = '0;
        for (int j = 0; j < 12; j++) begin
            req_valid = (j < 8);
            req_wen   = 1'b0;
            req_addr  = AW'(j % 8);
            @(negedge clk);
            vmask[j] = rsp_valid;
            if (j < 8) rdy_all &= req_ready;
            tick();
        end
        req_valid = 1'b0;
        total++;
        if (!rdy_all || vmask !== 12'h3FC) begin
            bad++;
            $display("FAIL stream_timing: ready_all %b valid %b, want 1/%b",
                     rdy_all, vmask, 12'h3FC);
        end
        total++;
        if (got_q.size() !== 8) begin
            bad++;
            $display("FAIL stream_count: got %0d, want 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== DW'(16'h1000 + i)) begin
                bad++;
                $display("FAIL stream_data[%0d]: got %h, want %h",
                         i, got_q[i], 16'h1000 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        for (int i = 0; i < 6; i++) issue(1'b1, 'h30 + i, DW'(16'h5000 + i));
        drain();
        clear_q();
        rsp_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1;
            req_wen   = 1'b0;
            req_addr  = AW'('h30 + n);
            @(negedge clk);
            if (req_ready) n++;
            tick();
        end
        @(negedge clk);
        total++;
        if (n !== 4 || req_ready !== 1'b0 || rsp_level !== 3'd4) begin
            bad++;
            $display("FAIL bp_stall: acc %0d ready %b level %0d, want 4/0/4",
                     n, req_ready, rsp_level);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_ready_comb: ready %b, want 0", req_ready);
        end
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_reopen: ready %b, want 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_level !== 3'd4 || got_q.size() !== 1) begin
            bad++;
            $display("FAIL bp_pop1: level %0d rsps %0d, want 4/1",
                     rsp_level, got_q.size());
        end
        tick();
        drain();
        total++;
        if (got_q.size() !== 5) begin
            bad++;
            $display("FAIL bp_count: got %0d, want 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== DW'(16'h5000 + i)) begin
                bad++;
                $display("FAIL bp_data[%0d]: got %h, want %h",
                         i, got_q[i], 16'h5000 + i);
            end
        end
    endtask

    task automatic test_hazard();
        issue(1'b1, 'h20, 16'h1111);
        drain();
        clear_q();
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = AW'('h20);
        tick();
        req_wen   = 1'b1;
        req_wdata = 16'h2222;
        tick();
        req_valid = 1'b0;
        tick();
        issue(1'b0, 'h20, '0);
        drain();
        total++;
        if (got_q.size() !== 2) begin
            bad++;
            $display("FAIL hazard_count: got %0d, want 2", got_q.size());
        end else begin
            total++;
            if (got_q[0] !== 16'h1111 || got_q[1] !== 16'h2222) begin
                bad++;
                $display("FAIL hazard_data: got %h %h, want 1111 2222",
                         got_q[0], got_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) issue(1'b1, 'h40 + i, DW'(16'h7000 + i));
        drain();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b0, 'h40 + i, '0);
        total++;
        if (rsp_level !== 3'd4 || rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_prefill: level %0d valid %b, want 4/1",
                     rsp_level, rsp_valid);
        end
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || rsp_level !== '0) begin
            bad++;
            $display("FAIL mid_flush: valid %b level %0d, want 0/0",
                     rsp_valid, rsp_level);
        end
        tick();
        clear_q();
        drain();
        total++;
        if (got_q.size() !== 0) begin
            bad++;
            $display("FAIL mid_ghost: got %0d rsps, want 0", got_q.size());
        end
        issue(1'b0, 'h42, '0);
        drain();
        total++;
        if (got_q.size() !== 1 || got_q[0] !== 16'h7002) begin
            bad++;
            $display("FAIL mid_fresh: rsps %0d, want 1 of 7002",
                     got_q.size());
        end
    endtask

    task automatic test_random();
        bit pending;
        clear_q();
        pending = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pending && ($urandom % 4 != 0)) begin
                pending   = 1'b1;
                req_wen   = ($urandom % 3 == 0);
                req_addr  = AW'($urandom_range(0, 15));
                req_wdata = DW'($urandom);
            end
            req_valid = pending;
            rsp_ready = ($urandom % 2 == 0);
            @(negedge clk);
            if (req_valid && req_ready) pending = 1'b0;
            tick();
        end
        drain();
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d, want %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_data[%0d]: got %h, want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            tmem[i] = '0;
            rmem[i] = '0;
        end
        test_reset();
        test_write_read();
        test_streaming();
        test_backpressure();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
